// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator feeding a DEPTH-entry valid/ready FIFO.
// Optional macro IMM_CSR_EN decodes SYSTEM/CSR immediates (ZIMM and I forms).
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    F_NONE, F_I, F_S, F_B, F_U, F_J, F_SHAMT, F_ZIMM
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [6:0] OP_LOAD = 7'd3,   OP_IMM   = 7'd19, OP_AUIPC = 7'd23;
  localparam logic [6:0] OP_IMM32 = 7'd27, OP_STORE = 7'd35, OP_OP    = 7'd51;
  localparam logic [6:0] OP_LUI  = 7'd55,  OP_OP32  = 7'd59, OP_BR    = 7'd99;
  localparam logic [6:0] OP_JALR = 7'd103, OP_JAL   = 7'd111, OP_FENCE = 7'd15;
  localparam logic [6:0] OP_SYS  = 7'd115;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t          dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  // RV32 shift amounts are only 5 bits; bit 25 belongs to funct7 there
  assign shamt  = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.fmt     = F_NONE;
    dec.tag     = in_tag;
    case (opcode)
      OP_LOAD: begin dec.fmt = F_I; dec.imm = imm_i; end
      OP_JALR:
        if (funct3 == 3'd0) begin dec.fmt = F_I; dec.imm = imm_i; end
        else dec.illegal = 1'b1;
      OP_IMM32:
        if (XLEN == 64) begin dec.fmt = F_I; dec.imm = imm_i; end
        else dec.illegal = 1'b1;
      OP_IMM:
        if (funct3 == 3'd1 || funct3 == 3'd5) begin
          dec.fmt = F_SHAMT; dec.imm = XLEN'(shamt);
        end else begin
          dec.fmt = F_I; dec.imm = imm_i;
        end
      OP_STORE:         begin dec.fmt = F_S; dec.imm = imm_s; end
      OP_BR:            begin dec.fmt = F_B; dec.imm = imm_b; end
      OP_LUI, OP_AUIPC: begin dec.fmt = F_U; dec.imm = imm_u; end
      OP_JAL:           begin dec.fmt = F_J; dec.imm = imm_j; end
`ifdef IMM_CSR_EN
      OP_SYS:
        if (funct3 >= 3'd5) begin
          dec.fmt = F_ZIMM; dec.imm = XLEN'(in_instr[19:15]);
        end else begin
          dec.fmt = F_I; dec.imm = imm_i;
        end
`else
      OP_SYS: ;
`endif
      OP_OP, OP_OP32, OP_FENCE: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop;
  entry_t        head;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; entries are only observable through count
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wptr] <= dec;
  end

  assign head        = mem[rptr];
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;
  assign out_tag     = head.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share one stimulus stream.
module tb_imm_gen_pipe;
  localparam int DEPTH = 2;
  localparam int TAG_W = 32;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [TAG_W-1:0] in_tag;

  logic r64, v64, il64, r32, v32, il32;
  logic [63:0] imm64;
  logic [31:0] imm32;
  logic [2:0] f64, f32;
  logic [TAG_W-1:0] t64, t32;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(f64), .out_illegal(il64), .out_tag(t64));

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(f32), .out_illegal(il32), .out_tag(t32));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Sign-extend the low b bits of v to 64 bits.
  function automatic logic [63:0] sext(input logic [63:0] v, input int b);
    logic [63:0] m, s;
    m = (64'd1 << b) - 64'd1;
    s = 64'd1 << (b - 1);
    return ((v & m) ^ s) - s;
  endfunction

  // Reference decoder straight from the opcode table; imm masked to xl bits.
  function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    int op, f3;
    op = ins[6:0]; f3 = ins[14:12];
    imm = 0; fmt = 0; ill = 0;
    case (op)
      3:   begin fmt = 1; imm = sext(64'(ins[31:20]), 12); end
      103: if (f3 == 0) begin fmt = 1; imm = sext(64'(ins[31:20]), 12); end else ill = 1;
      27:  if (xl == 64) begin fmt = 1; imm = sext(64'(ins[31:20]), 12); end else ill = 1;
      19:  if (f3 == 1 || f3 == 5) begin
             fmt = 6; imm = (xl == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
           end else begin fmt = 1; imm = sext(64'(ins[31:20]), 12); end
      35:  begin fmt = 2; imm = sext(64'({ins[31:25], ins[11:7]}), 12); end
      99:  begin fmt = 3; imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13); end
      55, 23: begin fmt = 4; imm = sext(64'({ins[31:12], 12'b0}), 32); end
      111: begin fmt = 5; imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21); end
`ifdef IMM_CSR_EN
      115: if (f3 >= 5) begin fmt = 7; imm = 64'(ins[19:15]); end
           else begin fmt = 1; imm = sext(64'(ins[31:20]), 12); end
`else
      115: ;
`endif
      51, 59, 15: ;
      default: ill = 1;
    endcase
    if (xl == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  typedef struct { logic [31:0] instr; logic [TAG_W-1:0] tag; } ent_t;
  ent_t q[$];

  // Scoreboard: compare on the falling edge, then advance the model for the next rising edge.
  always @(negedge clk) begin
    logic [63:0] ei; logic [2:0] ef; logic el;
    bit do_push, do_pop;
    if (chk_en) begin
      chk("valid64", 64'(v64), 64'(q.size() != 0));
      chk("ready64", 64'(r64), 64'(q.size() != DEPTH));
      chk("valid32", 64'(v32), 64'(q.size() != 0));
      chk("ready32", 64'(r32), 64'(q.size() != DEPTH));
      if (q.size() != 0) begin
        ref_dec(q[0].instr, 64, ei, ef, el);
        chk("imm64", imm64, ei); chk("fmt64", 64'(f64), 64'(ef));
        chk("ill64", 64'(il64), 64'(el)); chk("tag64", 64'(t64), 64'(q[0].tag));
        ref_dec(q[0].instr, 32, ei, ef, el);
        chk("imm32", 64'(imm32), ei); chk("fmt32", 64'(f32), 64'(ef));
        chk("ill32", 64'(il32), 64'(el)); chk("tag32", 64'(t32), 64'(q[0].tag));
      end
    end
    if (reset || flush) q.delete();
    else begin
      do_pop  = out_ready && q.size() != 0;
      do_push = in_valid && q.size() != DEPTH;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{in_instr, in_tag});
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic push1(input logic [31:0] ins, input logic [TAG_W-1:0] tg);
    in_valid = 1; in_instr = ins; in_tag = tg; tick; in_valid = 0;
  endtask

  task automatic pop1; out_ready = 1; tick; out_ready = 0; endtask

  logic [6:0] ops [15];
  initial begin
    ops = '{7'd3, 7'd19, 7'd23, 7'd27, 7'd35, 7'd51, 7'd55, 7'd59,
            7'd99, 7'd103, 7'd111, 7'd15, 7'd115, 7'h7F, 7'd0};
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_tag = 0;
    tick; tick; chk_en = 1; reset = 0;
    chk("rst_valid", 64'(v64), 64'd0); chk("rst_ready", 64'(r64), 64'd1);

    push1(32'hFFF00093, 1);
    chk("addi_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF); chk("addi_fmt", 64'(f64), 64'd1);
    chk("addi_ill", 64'(il64), 64'd0); chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    pop1;

    in_valid = 1; in_instr = 32'hFE113C23; in_tag = 2; tick;
    in_instr = 32'hFE000EE3; in_tag = 3; tick; in_valid = 0;
    chk("sd_imm", imm64, 64'hFFFF_FFFF_FFFF_FFF8); chk("sd_fmt", 64'(f64), 64'd2);
    pop1;
    chk("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC); chk("beq_fmt", 64'(f64), 64'd3);
    pop1;

    push1(32'h800000B7, 4);
    chk("lui_imm", imm64, 64'hFFFF_FFFF_8000_0000); chk("lui_fmt", 64'(f64), 64'd4);
    pop1;
    push1(32'h03F09093, 5);
    chk("slli_imm", imm64, 64'h3F); chk("slli_fmt", 64'(f64), 64'd6);
    chk("slli_imm32", 64'(imm32), 64'h1F);
    pop1;

    // backpressure: tag 3 must wait while full, then drain in order
    in_valid = 1; in_instr = 32'h00000013;
    in_tag = 1; tick; in_tag = 2; tick; in_tag = 3;
    chk("bp_full", 64'(r64), 64'd0);
    tick;
    chk("bp_hold", 64'(r64), 64'd0); chk("bp_head1", 64'(t64), 64'd1);
    out_ready = 1; tick;
    chk("bp_head2", 64'(t64), 64'd2);
    tick; in_valid = 0;
    chk("bp_head3", 64'(t64), 64'd3);
    tick; out_ready = 0;
    chk("bp_empty", 64'(v64), 64'd0);

    push1(32'h0000007F, 6);
    chk("bad_imm", imm64, 64'd0); chk("bad_fmt", 64'(f64), 64'd0);
    chk("bad_ill", 64'(il64), 64'd1);
    pop1;
    push1(32'h0010809B, 7);
    chk("w_ill64", 64'(il64), 64'd0); chk("w_imm64", imm64, 64'd1);
    chk("w_ill32", 64'(il32), 64'd1); chk("w_fmt32", 64'(f32), 64'd0);
    pop1;

    push1(32'h00100093, 8); push1(32'h00200093, 9);
    in_valid = 1; flush = 1; in_tag = 10; tick; in_valid = 0; flush = 0;
    chk("fl_valid", 64'(v64), 64'd0); chk("fl_ready", 64'(r64), 64'd1);
    tick; chk("fl_stay", 64'(v64), 64'd0);
    push1(32'h00100093, 11); push1(32'h00200093, 12);
    reset = 1; tick; reset = 0;
    chk("rs_valid", 64'(v64), 64'd0); chk("rs_ready", 64'(r64), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      in_instr  = {$urandom()} & 32'hFFFF_FF80;
      in_instr[6:0] = ops[$urandom_range(0, 14)];
      if ($urandom_range(0, 15) == 0) in_instr[6:0] = 7'($urandom());
      in_tag    = $urandom();
      tick;
    end
    in_valid = 0; out_ready = 0; flush = 0; reset = 0;
    tick; tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised RISC-V immediate generator. Supersedes the combinational sign extender.
- Decodes every base-ISA immediate format with correct sign or zero extension to XLEN.
- Buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between fetch/IR and the decode/execute stage. Carries an opaque tag (for example, PC) alongside each result.

Parameters:
XLEN, 64, output immediate width; legal values 32 or 64
DEPTH, 2, FIFO entries; power of two, >= 2
TAG_W, 32, width of sideband tag carried with each instruction

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  instruction present
in_ready  output  1  block can accept; equals (count != DEPTH)
in_instr  input  32  instruction word
in_tag  input  TAG_W  sideband tag
out_valid  output  1  head entry valid; equals (count != 0)
out_ready  input  1  consumer accepts head
out_imm  output  XLEN  extended immediate of head entry
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
out_illegal  output  1  opcode not recognised
out_tag  output  TAG_W  tag of head entry

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset state:
  - count=0, read/write pointers=0, so out_valid=0 and in_ready=1.
  - Storage is not cleared; out_imm, out_fmt, out_illegal and out_tag are don't-care while out_valid=0.
- Transfers:
  - Push on a cycle with in_valid && in_ready.
  - Pop on a cycle with out_valid && out_ready.
- Latency: an instruction pushed at edge N is visible at the head after edge N, when the FIFO was empty. There is no combinational in-to-out path.
- Decode happens at push time; the FIFO stores {imm, fmt, illegal, tag}.
- Opcode map (in_instr[6:0]); all immediates are sign-extended from the top immediate bit unless noted:
  - 3 (LOAD), 103 (JALR, funct3=0), 27 (OP-IMM-32, XLEN=64 only): I, imm[11:0]=instr[31:20].
  - 19 (OP-IMM):
    - funct3 1 or 5: SHAMT, zero-extended. instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
    - Other funct3: I.
  - 35: S, {instr[31:25], instr[11:7]}.
  - 99: B, {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 55 (LUI), 23 (AUIPC): U, {instr[31:12], 12'b0}, sign-extended from bit 31.
  - 111: J, {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 51, 59 (R-type), 15 (FENCE), 115 (SYSTEM, macro off): fmt NONE, imm 0, illegal 0.
  - JALR with funct3 != 0, opcode 27 when XLEN=32, any other opcode: fmt NONE, imm 0, illegal 1.
- Simultaneous push and pop:
  - Not full: both occur and count is unchanged.
  - Full: in_ready=0, so only the pop occurs.
  - Empty: out_valid=0, so only the push occurs.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Priority: reset > flush > push/pop.
  - Flush sets count and both pointers to 0.
  - A push in the flush cycle is discarded.
- Order is strictly FIFO. Head outputs are stable while out_valid && !out_ready.

Optional Feature:
- Macro IMM_CSR_EN.
- Defined:
  - Opcode 115 with funct3 in {5,6,7}: fmt ZIMM, imm = zero-extended instr[19:15], illegal 0.
  - Opcode 115 with other funct3: I, sign-extended instr[31:20].
- Undefined: opcode 115 gives fmt NONE, imm 0, illegal 0.

Test Plan:
- XLEN=64, push 0xFFF00093 (addi -1), out_ready=1 -> next cycle: out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0.
- Push 0xFE113C23 (sd x1,-8(x2)) then 0xFE000EE3 (beq -4) back-to-back -> heads in order: imm 0xFFFFFFFFFFFFFFF8 fmt=2, then 0xFFFFFFFFFFFFFFFC fmt=3.
- Push 0x800000B7 (lui 0x80000) -> imm 0xFFFFFFFF80000000, fmt=4. Push 0x03F09093 (slli 63) -> imm 0x3F, fmt=6.
- Backpressure with DEPTH=2, out_ready=0: push tags 1,2,3 -> in_ready drops after the 2nd push, tag 3 held. Raise out_ready -> tags 1,2,3 emerge in order with no loss or duplication.
- Push 0x0000007F -> imm 0, fmt=0, illegal=1. With XLEN=32, push 0x0010809B -> illegal=1.
- Fill 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted. Assert reset with entries held -> same result.
